config_chain_writer: RTL

CONFIG_CHAIN_WRITER -- requirements
Module: config_chain_writer

---
 rtl/config_chain_writer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/config_chain_writer.sv
// config_chain_writer
//   Streams a CHAIN_LEN-bit configuration frame, LSB first, into a two-phase
//   latch chain. For each bit, CONF_DATA is set up, then CONF_PHA pulses, then
//   CONF_PHB pulses. A guard gap follows each pulse, so the two strobes never
//   overlap. Frame words arrive 32 bits at a time on a valid/ready stream.
//
//   Optional build macro: CONFIG_CHAIN_WRITER_READBACK_EN.
//   When defined, the chain's return bit is captured once per bit and
//   delivered as 32-bit words on rb_valid/rb_data/rb_ready.
//
// Ports
//   CLK, RESETn             system clock, async active-low reset
//   start                   one-cycle frame request (ignored unless idle)
//   busy, done              frame in progress / one-cycle completion pulse
//   s_valid, s_ready, s_data  32-bit frame word stream
//   CONF_DATA               serial data to the first CONFin of the chain
//   CONF_PHA, CONF_PHB      phase strobes (registered, non-overlapping)
//   CONF_RET                last CONFout of the chain (readback builds only)
//   rb_valid, rb_data, rb_ready  readback word stream (readback builds only)
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | s_ready high, waiting for the next frame word
// SETUP | CONF_DATA settles before the strobes
// PHA   | phase-A strobe high for PULSE_W cycles
// GAP1  | both strobes low for GAP_W cycles
// PHB   | phase-B strobe high for PULSE_W cycles
// GAP2  | both strobes low for GAP_W cycles; can stall on readback backpressure
// DONE  | done pulse, back to IDLE

module config_chain_writer #(
  parameter int CHAIN_LEN = 64,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        CONF_DATA,
  output logic        CONF_PHA,
  output logic        CONF_PHB,
  input  logic        CONF_RET
`ifdef CONFIG_CHAIN_WRITER_READBACK_EN
  ,
  output logic        rb_valid,
  output logic [31:0] rb_data,
  input  logic        rb_ready
`endif
);

  localparam int CBW  = $clog2(CHAIN_LEN + 1);
  localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CBW-1:0] LAST_BIT = CBW'(CHAIN_LEN - 1);
  localparam logic [TW-1:0]  PULSE_LD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0]  GAP_LD   = TW'(GAP_W - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, PHA, GAP1, PHB, GAP2, DONE
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer;
  logic [CBW-1:0]  bit_cnt;
  logic [4:0]      word_idx;
  logic [31:0]     shifter;
  logic            tmr_zero;
  logic            last_bit;
  logic            word_end;
  logic            rb_stall;
  logic            advance;

  assign tmr_zero = (timer == '0);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign word_end = (word_idx == 5'd31);
  // GAP2 is left only once its timer expires and no readback word is pending.
  assign advance  = (state == GAP2) && tmr_zero && !rb_stall;

  // The shifter is a flop, so CONF_DATA comes straight from a register. It
  // only moves on a word load or between bits, so it is stable from SETUP
  // through GAP2 and holds while LOAD is starved.
  assign CONF_DATA = shifter[0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (s_valid && s_ready) state_nx = SETUP;
      SETUP: state_nx = PHA;
      PHA:   if (tmr_zero) state_nx = GAP1;
      GAP1:  if (tmr_zero) state_nx = PHB;
      PHB:   if (tmr_zero) state_nx = GAP2;
      GAP2: begin
        if (advance) begin
          if (last_bit)      state_nx = DONE;
          else if (word_end) state_nx = LOAD;
          else               state_nx = SETUP;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
      shifter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_ready  <= 1'b0;
      CONF_PHA <= 1'b0;
      CONF_PHB <= 1'b0;
    end else begin
      state <= state_nx;

      // Outputs are registered decodes of the next state, so each one comes
      // straight from a flop and lines up with the state it belongs to.
      busy     <= (state_nx != IDLE) && (state_nx != DONE);
      done     <= (state_nx == DONE);
      s_ready  <= (state_nx == LOAD);
      CONF_PHA <= (state_nx == PHA);
      CONF_PHB <= (state_nx == PHB);

      // The down-counter is loaded on entry to each timed state and then
      // counts to zero. Zero marks the last cycle of that state.
      if (state_nx != state) begin
        case (state_nx)
          PHA, PHB:   timer <= PULSE_LD;
          GAP1, GAP2: timer <= GAP_LD;
          default:    timer <= '0;
        endcase
      end else if (!tmr_zero) begin
        timer <= timer - TW'(1);
      end

      if (state == IDLE && start) begin
        bit_cnt  <= '0;
        word_idx <= '0;
      end

      if (state == LOAD && s_valid && s_ready) begin
        shifter <= s_data;
      end

      if (advance) begin
        bit_cnt  <= bit_cnt + CBW'(1);
        word_idx <= word_idx + 5'd1;
        if (state_nx == SETUP) begin
          shifter <= {1'b0, shifter[31:1]};
        end
      end
    end
  end

`ifdef CONFIG_CHAIN_WRITER_READBACK_EN
  logic [31:0] rb_acc;
  logic [31:0] rb_word;

  assign rb_stall = rb_valid && !rb_ready;

  always_comb begin
    rb_word           = rb_acc;
    rb_word[word_idx] = CONF_RET;
  end

  // CONF_RET is captured in the last PHB cycle of each bit. A word is
  // published after its 32nd bit or after the final bit of the frame. A
  // partial last word stays zero in its upper bits because the accumulator
  // is cleared at every publish.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rb_acc   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      if (rb_valid && rb_ready) begin
        rb_valid <= 1'b0;
      end
      if (state == IDLE && start) begin
        rb_acc <= '0;
      end
      if (state == PHB && tmr_zero) begin
        if (word_end || last_bit) begin
          rb_data  <= rb_word;
          rb_valid <= 1'b1;
          rb_acc   <= '0;
        end else begin
          rb_acc <= rb_word;
        end
      end
    end
  end
`else
  logic unused_conf_ret;
  assign unused_conf_ret = CONF_RET;
  assign rb_stall        = 1'b0;
`endif

endmodule
